// File: rtl/nibbler_pkg.sv
// Shared types for the nibble-stream program loader and the Fetch stage:
// loader FSM states and the {instruction, operand} byte layout.
package nibbler_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        DONE
    } loader_state_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] instr;
        logic [NIBBLE_W-1:0] operand;
    } byte_t;

endpackage

// File: rtl/nib_packer.sv
// Assembles a high nibble and the following low nibble into one byte_t;
// byte_valid pulses in the cycle the low nibble is taken.
module nib_packer
    import nibbler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                hi_take,
    input  logic                lo_take,
    input  logic [NIBBLE_W-1:0] nib_data,
    output byte_t               packed_byte,
    output logic                byte_valid
);

    logic [NIBBLE_W-1:0] hi_nib;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_nib <= '0;
        end else if (hi_take) begin
            hi_nib <= nib_data;
        end
    end

    always_comb begin
        packed_byte.instr   = hi_nib;
        packed_byte.operand = nib_data;
        byte_valid          = lo_take;
    end

endmodule

// File: rtl/prog_loader.sv
// Packs a nibble stream into program RAM from address 0 while holding the CPU.
// Optional LOADER_CHECKSUM_EN: last byte is a mod-256 checksum, adds csum_ok.
module prog_loader
    import nibbler_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                nib_valid,
    input  logic [NIBBLE_W-1:0] nib_data,
    input  logic                nib_last,
    output logic                nib_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     byte_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                csum_ok
`endif
);

    // byte_count doubles as the write pointer; it saturates at MEM_DEPTH
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(MEM_DEPTH);

    loader_state_t state;
    logic          xfer;
    byte_t         packed_byte;
    logic          byte_valid;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`else
    logic          last_seen;
`endif

    assign nib_ready = (state == HI) || (state == LO);
    assign xfer      = nib_valid && nib_ready;

    nib_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .hi_take     (xfer && (state == HI)),
        .lo_take     (xfer && (state == LO)),
        .nib_data    (nib_data),
        .packed_byte (packed_byte),
        .byte_valid  (byte_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
            csum_ok    <= 1'b0;
`else
            last_seen  <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= HI;
                        err        <= 1'b0;
                        byte_count <= '0;
                        cpu_hold   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= '0;
                        csum_ok    <= 1'b0;
`endif
                    end
                end
                HI: begin
                    // A session may not end on a high nibble, nor grow past the memory
                    if (xfer) begin
                        if (nib_last || (byte_count == FULL_COUNT)) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= LO;
                        end
                    end
                end
                LO: begin
                    if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        if (nib_last) begin
                            cpu_hold <= 1'b0;
                            if (packed_byte == sum) begin
                                csum_ok <= 1'b1;
                                done    <= 1'b1;
                                state   <= DONE;
                            end else begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            mem_we   <= 1'b1;
                            mem_addr <= byte_count[ADDR_W-1:0];
                            mem_data <= packed_byte;
                            sum      <= sum + 8'(packed_byte);
                            state    <= WRITE;
                        end
`else
                        mem_we    <= 1'b1;
                        mem_addr  <= byte_count[ADDR_W-1:0];
                        mem_data  <= packed_byte;
                        last_seen <= nib_last;
                        state     <= WRITE;
`endif
                    end
                end
                WRITE: begin
                    byte_count <= byte_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    state <= HI;
`else
                    if (last_seen) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= DONE;
                    end else begin
                        state <= HI;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (ADDR_W=4, MEM_DEPTH=4); the
// LOADER_CHECKSUM_EN build swaps the plain load tests for checksum tests.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       nib_valid = 1'b0;
    logic [3:0] nib_data = 4'h0;
    logic       nib_last = 1'b0;
    logic       nib_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [4:0] byte_count;
`ifdef LOADER_CHECKSUM_EN
    logic       csum_ok;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;

    prog_loader #(.ADDR_W(4), .MEM_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .nib_last   (nib_last),
        .nib_ready  (nib_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .csum_ok    (csum_ok)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic expectWrite(input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic expectDone();
        ev_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    // Offers one nibble until accepted (bounded), then idles nib_valid for gap cycles
    task automatic applyStimulus(input logic [3:0] nib, input logic last, input int gap);
        int waited = 0;
        nib_valid = 1'b1;
        nib_data  = nib;
        nib_last  = last;
        while (!nib_ready && waited < 20) begin
            idle(1);
            waited++;
        end
        checkOutput("nib_ready_wait", {31'b0, nib_ready}, 1);
        if (nib_ready) idle(1);
        nib_valid = 1'b0;
        nib_last  = 1'b0;
        idle(gap);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            checkOutput("ready_in_write", {31'b0, nib_ready}, 0);
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=none", mem_addr, mem_data);
            end else begin
                ev = exp_q.pop_front();
                checkOutput("wr_addr", {28'b0, mem_addr}, {28'b0, ev.addr});
                checkOutput("wr_data", {24'b0, mem_data}, {24'b0, ev.data});
            end
        end
        if (done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                ev = exp_q.pop_front();
                checkOutput("done_cpu_hold", {31'b0, cpu_hold}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Power-on reset values
        #2;
        checkOutput("rst_nib_ready", {31'b0, nib_ready}, 0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 0);
        checkOutput("rst_mem_addr", {28'b0, mem_addr}, 0);
        checkOutput("rst_mem_data", {24'b0, mem_data}, 0);
        checkOutput("rst_cpu_hold", {31'b0, cpu_hold}, 0);
        checkOutput("rst_done", {31'b0, done}, 0);
        checkOutput("rst_err", {31'b0, err}, 0);
        checkOutput("rst_byte_count", {27'b0, byte_count}, 0);
        idle(2);
        reset = 1'b1;
        idle(2);

        // Reset in the middle of a session
        pulseStart();
        checkOutput("mid_cpu_hold", {31'b0, cpu_hold}, 1);
        expectWrite(4'd0, 8'h49);
        applyStimulus(4'h4, 1'b0, 0);
        applyStimulus(4'h9, 1'b0, 0);
        applyStimulus(4'h1, 1'b0, 0);
        reset = 1'b0;
        #1;
        checkOutput("mid_nib_ready", {31'b0, nib_ready}, 0);
        checkOutput("mid_mem_we", {31'b0, mem_we}, 0);
        checkOutput("mid_mem_addr", {28'b0, mem_addr}, 0);
        checkOutput("mid_mem_data", {24'b0, mem_data}, 0);
        checkOutput("mid_cpu_hold_rst", {31'b0, cpu_hold}, 0);
        checkOutput("mid_byte_count", {27'b0, byte_count}, 0);
        idle(2);
        reset = 1'b1;
        nib_valid = 1'b1;
        nib_data  = 4'h2;
        nib_last  = 1'b1;
        idle(4);
        checkOutput("mid_no_accept", {31'b0, nib_ready}, 0);
        nib_valid = 1'b0;
        nib_last  = 1'b0;
        idle(2);
        checkOutput("mid_queue_empty", exp_q.size(), 0);

`ifndef LOADER_CHECKSUM_EN
        // Basic two-byte load
        pulseStart();
        expectWrite(4'd0, 8'h49);
        applyStimulus(4'h4, 1'b0, 0);
        applyStimulus(4'h9, 1'b0, 0);
        expectWrite(4'd1, 8'h12);
        expectDone();
        applyStimulus(4'h1, 1'b0, 0);
        applyStimulus(4'h2, 1'b1, 0);
        idle(4);
        checkOutput("basic_byte_count", {27'b0, byte_count}, 2);
        checkOutput("basic_err", {31'b0, err}, 0);
        checkOutput("basic_cpu_hold", {31'b0, cpu_hold}, 0);
        checkOutput("basic_queue_empty", exp_q.size(), 0);

        // Gaps in nib_valid and a high nibble offered during WRITE
        pulseStart();
        expectWrite(4'd0, 8'h3C);
        applyStimulus(4'h3, 1'b0, 2);
        applyStimulus(4'hC, 1'b0, 0);
        expectWrite(4'd1, 8'h56);
        expectDone();
        applyStimulus(4'h5, 1'b0, 3);
        checkOutput("stall_cpu_hold", {31'b0, cpu_hold}, 1);
        applyStimulus(4'h6, 1'b1, 1);
        idle(4);
        checkOutput("stall_byte_count", {27'b0, byte_count}, 2);
        checkOutput("stall_queue_empty", exp_q.size(), 0);
`else
        // Matching checksum
        pulseStart();
        expectWrite(4'd0, 8'h10);
        applyStimulus(4'h1, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, 0);
        expectWrite(4'd1, 8'h20);
        applyStimulus(4'h2, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, 0);
        expectDone();
        applyStimulus(4'h3, 1'b0, 0);
        applyStimulus(4'h0, 1'b1, 0);
        idle(4);
        checkOutput("csum_ok_good", {31'b0, csum_ok}, 1);
        checkOutput("csum_err_good", {31'b0, err}, 0);
        checkOutput("csum_count_good", {27'b0, byte_count}, 2);
        checkOutput("csum_queue_good", exp_q.size(), 0);

        // Wrong checksum
        pulseStart();
        expectWrite(4'd0, 8'h10);
        applyStimulus(4'h1, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, 0);
        expectWrite(4'd1, 8'h20);
        applyStimulus(4'h2, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, 0);
        applyStimulus(4'h3, 1'b0, 0);
        applyStimulus(4'h1, 1'b1, 0);
        idle(4);
        checkOutput("csum_ok_bad", {31'b0, csum_ok}, 0);
        checkOutput("csum_err_bad", {31'b0, err}, 1);
        checkOutput("csum_cpu_hold_bad", {31'b0, cpu_hold}, 0);
        checkOutput("csum_queue_bad", exp_q.size(), 0);
`endif

        // Odd nibble count
        pulseStart();
        expectWrite(4'd0, 8'hAB);
        applyStimulus(4'hA, 1'b0, 0);
        applyStimulus(4'hB, 1'b0, 0);
        applyStimulus(4'hC, 1'b1, 0);
        idle(4);
        checkOutput("odd_err", {31'b0, err}, 1);
        checkOutput("odd_byte_count", {27'b0, byte_count}, 1);
        checkOutput("odd_cpu_hold", {31'b0, cpu_hold}, 0);
        checkOutput("odd_queue_empty", exp_q.size(), 0);

        // Overflow past MEM_DEPTH=4
        pulseStart();
        checkOutput("ovf_err_cleared", {31'b0, err}, 0);
        checkOutput("ovf_count_cleared", {27'b0, byte_count}, 0);
        expectWrite(4'd0, 8'h01);
        applyStimulus(4'h0, 1'b0, 0);
        applyStimulus(4'h1, 1'b0, 0);
        expectWrite(4'd1, 8'h23);
        applyStimulus(4'h2, 1'b0, 0);
        applyStimulus(4'h3, 1'b0, 0);
        expectWrite(4'd2, 8'h45);
        applyStimulus(4'h4, 1'b0, 0);
        applyStimulus(4'h5, 1'b0, 0);
        expectWrite(4'd3, 8'h67);
        applyStimulus(4'h6, 1'b0, 0);
        applyStimulus(4'h7, 1'b0, 0);
        applyStimulus(4'h8, 1'b0, 0);
        nib_valid = 1'b1;
        nib_data  = 4'h9;
        idle(3);
        checkOutput("ovf_10th_refused", {31'b0, nib_ready}, 0);
        nib_valid = 1'b0;
        idle(2);
        checkOutput("ovf_err", {31'b0, err}, 1);
        checkOutput("ovf_mem_addr", {28'b0, mem_addr}, 3);
        checkOutput("ovf_mem_data", {24'b0, mem_data}, 8'h67);
        checkOutput("ovf_byte_count", {27'b0, byte_count}, 4);
        checkOutput("ovf_cpu_hold", {31'b0, cpu_hold}, 0);
        checkOutput("ovf_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program-memory fetch interface: packs incoming nibble stream into 8-bit instruction bytes and writes them into program memory starting at address 0.
- Byte layout matches what Fetch consumes, {instruction[3:0], operand[3:0]}: first nibble received is the instruction (high), second is the operand (low).
- Holds the CPU (Phase/Fetch) idle via cpu_hold while loading; sits between the external load port and program RAM.

Parameters:
- ADDR_W, 12, program memory address width.
- MEM_DEPTH, 4096, number of writable bytes; must be <= 2**ADDR_W.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- nib_valid  in  1  nibble available on nib_data.
- nib_data  in  4  nibble; high nibble first, then low nibble.
- nib_last  in  1  qualifies the final nibble of the session; valid only with nib_valid.
- nib_ready  out  1  loader accepts nibble this cycle.
- mem_we  out  1  one-cycle write strobe to program RAM.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  8  {instruction, operand} byte.
- cpu_hold  out  1  high while a session is active; CPU must not fetch.
- done  out  1  one-cycle pulse at successful session end.
- err  out  1  sticky error; cleared by next start or reset.
- byte_count  out  ADDR_W+1  bytes written in current/last session.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; nib_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, done=0, err=0, byte_count=0. Reset mid-session abandons it; no further writes.
- Handshake: nibble transferred on rising clk when nib_valid && nib_ready. nib_ready is registered-free combinational from state: 1 in HI and LO, 0 elsewhere.
- States:
  - IDLE: start -> HI; clears err, byte_count, address pointer; cpu_hold=1 from next cycle.
  - HI: on transfer capture nib_data into hi register -> LO. If nib_last with high nibble -> err=1 (odd nibble count), -> IDLE.
  - LO: on transfer, mem_data<={hi,nib_data}, mem_addr<=pointer, mem_we=1 next cycle -> WRITE; remember nib_last.
  - WRITE: one cycle, mem_we=1; pointer and byte_count increment. If last -> DONE, else -> HI.
  - DONE: done=1 for one cycle, cpu_hold=0 -> IDLE.
- Latency: byte written (mem_we high) exactly 1 cycle after its low nibble is accepted; max throughput 2 nibbles per 3 cycles.
- Full: if byte_count reaches MEM_DEPTH and a further high nibble is accepted -> err=1, no write, -> IDLE, cpu_hold drops. Pointer never wraps.
- start while not IDLE is ignored. nib_valid in IDLE/WRITE/DONE is not accepted (nib_ready=0); producer holds data.
- Error exit: no done pulse; cpu_hold deasserts the cycle after err sets.
- mem_addr/mem_data hold last written values between writes.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- With it: loader keeps an 8-bit modulo-256 sum of all written bytes; the final byte of the session (the one flagged by nib_last) is a checksum and is NOT written to memory nor counted. If sum of data bytes != checksum -> err=1 and no done pulse; otherwise done as normal. Adds output csum_ok (1 bit, reset 0, valid after session end).
- Without it: every byte is data, written and counted; csum_ok port absent.

Decomposition:
- Shared package nibbler_pkg: loader state enum (IDLE, HI, LO, WRITE, DONE), typedef byte_t = {instr nibble, operand nibble} struct shared with Fetch, constant NIBBLE_W=4.
- Sub-module nib_packer (HI/LO assembly into byte_t with valid pulse) is natural; address/count/err control stays in prog_loader.

Test Plan:
- Reset mid-load: after 3 nibbles assert reset low -> all outputs 0 immediately, no mem_we after release.
- Basic load: start, nibbles 4,9,1,2(last) -> mem_we at addr 0 data 0x49, addr 1 data 0x12, done pulse, byte_count=2, cpu_hold low after done.
- Backpressure/stall: nib_valid toggled 1,0,1 with gaps -> same bytes, no duplicates, nib_ready 0 during WRITE cycle.
- Odd count: nibbles 0xA, 0xB, 0xC(last) -> one write 0xAB at 0, err=1, no done.
- Overflow with MEM_DEPTH=4: 10 nibbles -> writes at addr 0..3 only, err=1 on 9th nibble, mem_addr stays 3.
- LOADER_CHECKSUM_EN: bytes 0x10,0x20, checksum 0x30 -> 2 writes, csum_ok=1, done; checksum 0x31 -> err=1, csum_ok=0.
